sseg_ser: RTL and testbench

SSEG_SER -- requirements
Module: sseg_ser

---
 rtl/sseg_ser_pkg.sv | 16 +
 rtl/sseg_ser_shreg.sv | 40 ++++
 rtl/sseg_ser.sv | 118 +++++++++++
 tb/tb_sseg_ser.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_ser_pkg.sv
// Shared types and default sizing for the 74HC164 seven-segment serialiser.
package sseg_ser_pkg;

   // 8 digits x 8 segments per frame; the counter is wide enough to index them.
   localparam int C_DATA_BITS       = 64;
   localparam int C_DATA_COUNT_BITS = 6;

   // Frame sequencer: each bit takes a low half-cycle and a high half-cycle of seg_clk.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LATCH    = 2'd3
   } state_t;

endpackage

// File: rtl/sseg_ser_shreg.sv
// Loadable left-shift register feeding the serial data line, MSB first.
// Optional build macro SSEG_SER_INVERT_EN loads the complement of the
// parallel pattern (for common-anode displays with active-low segments).
module sseg_ser_shreg
   import sseg_ser_pkg::*;
#(
   parameter int WIDTH = C_DATA_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_msb
);

   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] w_load_val;

`ifdef SSEG_SER_INVERT_EN
   assign w_load_val = ~i_data;
`else
   assign w_load_val = i_data;
`endif

   // Load has priority; a shift pushes zeros in so the register is empty after a full frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sreg <= '0;
      end else if (i_load) begin
         r_sreg <= w_load_val;
      end else if (i_shift) begin
         r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
      end
   end

   // The MSB flop drives the pin directly, so serial data is already registered.
   assign o_msb = r_sreg[WIDTH-1];

endmodule

// File: rtl/sseg_ser.sv
// Seven-segment frame serialiser for a 74HC164 shift-register chain.
// Sequencer and bit counter live here; the data path is in sseg_ser_shreg.
// Optional build macro: SSEG_SER_INVERT_EN (inverted segment pattern).
module sseg_ser
   import sseg_ser_pkg::*;
#(
   parameter int DATA_BITS       = C_DATA_BITS,
   parameter int DATA_COUNT_BITS = C_DATA_COUNT_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Start,
   input  logic [DATA_BITS-1:0] P_Data,
   output logic                 busy,
   output logic                 done,
   output logic                 seg_clk,
   output logic                 seg_sout,
   output logic                 seg_clrn,
   output logic                 seg_pen
);

   localparam logic [DATA_COUNT_BITS-1:0] C_LAST = DATA_COUNT_BITS'(DATA_BITS - 1);

   state_t                     r_state;
   state_t                     w_state_next;
   logic [DATA_COUNT_BITS-1:0] r_count;
   logic                       w_load;
   logic                       w_shift;
   logic                       w_last;
   logic                       r_busy;
   logic                       r_done;
   logic                       r_seg_clk;
   logic                       r_seg_clrn;
   logic                       r_seg_pen;

   assign w_last = (r_count == C_LAST);

   // Next-state decode plus the shift-register load/shift strobes.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_shift      = 1'b0;
      case (r_state)
         IDLE: begin
            if (Start) begin
               w_load       = 1'b1;
               w_state_next = SHIFT_LO;
            end
         end
         SHIFT_LO: w_state_next = SHIFT_HI;
         SHIFT_HI: begin
            w_shift      = 1'b1;
            w_state_next = w_last ? LATCH : SHIFT_LO;
         end
         LATCH:    w_state_next = IDLE;
         default:  w_state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Bit counter; holds at the last index on the final exit so it never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (w_load) begin
         r_count <= '0;
      end else if (w_shift && !w_last) begin
         r_count <= r_count + DATA_COUNT_BITS'(1);
      end
   end

   // Outputs are decoded from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_seg_clk  <= 1'b0;
         r_seg_clrn <= 1'b0;
         r_seg_pen  <= 1'b0;
      end else begin
         r_busy     <= (w_state_next != IDLE);
         r_done     <= (w_state_next == LATCH);
         r_seg_clk  <= (w_state_next == SHIFT_HI);
         r_seg_clrn <= 1'b1;
         if (w_state_next == LATCH) begin
            r_seg_pen <= 1'b1;
         end else if (w_state_next == SHIFT_LO || w_state_next == SHIFT_HI) begin
            r_seg_pen <= 1'b0;
         end
      end
   end

   sseg_ser_shreg #(
      .WIDTH   (DATA_BITS)
   ) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (P_Data),
      .o_msb   (seg_sout)
   );

   assign busy     = r_busy;
   assign done     = r_done;
   assign seg_clk  = r_seg_clk;
   assign seg_clrn = r_seg_clrn;
   assign seg_pen  = r_seg_pen;

endmodule

// File: tb/tb_sseg_ser.sv
// Bench for sseg_ser: a 64-bit instance and a 16-bit instance, checked every
// cycle against a frame-position model plus directed literal expectations.
module tb_sseg_ser;

   logic        clk;
   logic        rst;
   logic [1:0]  start;
   logic [63:0] pdata0;
   logic [15:0] pdata1;
   logic [1:0]  busy_w, done_w, sclk_w, sout_w, clrn_w, pen_w;

   int checks = 0;
   int errors = 0;

`ifdef SSEG_SER_INVERT_EN
   localparam logic [63:0] INV = '1;
`else
   localparam logic [63:0] INV = '0;
`endif

   sseg_ser u_dut64 (
      .clk      (clk),
      .rst      (rst),
      .Start    (start[0]),
      .P_Data   (pdata0),
      .busy     (busy_w[0]),
      .done     (done_w[0]),
      .seg_clk  (sclk_w[0]),
      .seg_sout (sout_w[0]),
      .seg_clrn (clrn_w[0]),
      .seg_pen  (pen_w[0])
   );

   sseg_ser #(
      .DATA_BITS       (16),
      .DATA_COUNT_BITS (4)
   ) u_dut16 (
      .clk      (clk),
      .rst      (rst),
      .Start    (start[1]),
      .P_Data   (pdata1),
      .busy     (busy_w[1]),
      .done     (done_w[1]),
      .seg_clk  (sclk_w[1]),
      .seg_sout (sout_w[1]),
      .seg_clrn (clrn_w[1]),
      .seg_pen  (pen_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int width_of(input int c);
      return (c == 0) ? 64 : 16;
   endfunction

   // Model: m_t is the position within a frame (0 = idle, 1..2W shifting, 2W+1 latch).
   int          m_t[2];
   logic [63:0] m_data[2];
   logic        m_pen[2];
   logic        m_clrn[2];
   logic        m_valid = 1'b0;

   always @(posedge clk) begin
      int          w;
      logic [63:0] pd;
      for (int c = 0; c < 2; c++) begin
         w  = width_of(c);
         pd = (c == 0) ? pdata0 : {48'h0, pdata1};
         pd = pd ^ INV;
         if (rst) begin
            m_t[c]    = 0;
            m_pen[c]  = 1'b0;
            m_clrn[c] = 1'b0;
            m_valid   = 1'b1;
         end else begin
            m_clrn[c] = 1'b1;
            if (m_t[c] == 0) begin
               if (start[c]) begin
                  m_data[c] = pd;
                  m_t[c]    = 1;
                  m_pen[c]  = 1'b0;
               end
            end else if (m_t[c] == 2 * w + 1) begin
               m_t[c] = 0;
            end else begin
               m_t[c] = m_t[c] + 1;
               if (m_t[c] == 2 * w + 1) m_pen[c] = 1'b1;
            end
         end
      end
   end

   // Per-frame observations used by the directed checks.
   int          rises[2], busy_run[2], idle_run[2], last_busy_len[2], last_idle_len[2];
   int          done_pos[2], done_cnt[2];
   logic [63:0] cap[2];
   logic        prev_busy[2], prev_clk[2];

   initial begin
      for (int c = 0; c < 2; c++) begin
         rises[c] = 0; busy_run[c] = 0; idle_run[c] = 0; last_busy_len[c] = 0;
         last_idle_len[c] = 0; done_pos[c] = 0; done_cnt[c] = 0; cap[c] = '0;
         prev_busy[c] = 1'b0; prev_clk[c] = 1'b0;
      end
   end

   // Compare against the model on every cycle, then update the frame observations.
   always @(negedge clk) begin
      int       t, w;
      logic     shifting;
      logic [5:0] e, a;
      for (int c = 0; c < 2; c++) begin
         if (m_valid) begin
            t        = m_t[c];
            w        = width_of(c);
            shifting = (t >= 1) && (t <= 2 * w);
            e = {t != 0, t == 2 * w + 1, shifting && (t % 2 == 0), m_pen[c], m_clrn[c],
                 shifting ? m_data[c][w - 1 - (t - 1) / 2] : 1'b0};
            a = {busy_w[c], done_w[c], sclk_w[c], pen_w[c], clrn_w[c],
                 shifting ? sout_w[c] : 1'b0};
            checks++;
            if (e !== a) begin
               errors++;
               $display("FAIL cycle ch=%0d pos=%0d {busy,done,clk,pen,clrn,sout} got=%b want=%b",
                        c, t, a, e);
            end
         end
         if (busy_w[c]) begin
            if (!prev_busy[c]) begin
               last_idle_len[c] = idle_run[c];
               busy_run[c] = 0; rises[c] = 0; cap[c] = '0;
            end
            busy_run[c]++;
         end else begin
            if (prev_busy[c]) begin
               last_busy_len[c] = busy_run[c];
               idle_run[c] = 0;
            end
            idle_run[c]++;
         end
         if (sclk_w[c] && !prev_clk[c]) begin
            rises[c]++;
            cap[c] = {cap[c][62:0], sout_w[c]};
         end
         if (done_w[c]) begin
            done_cnt[c]++;
            done_pos[c] = busy_run[c];
            $display("frame ch=%0d done at cycle %0d rises=%0d stream=%h", c, busy_run[c], rises[c], cap[c]);
         end
         prev_busy[c] = busy_w[c];
         prev_clk[c]  = sclk_w[c];
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic wait_done(input int c);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!done_w[c] && n < 400);
      checks++;
      if (!done_w[c]) begin
         errors++;
         $display("FAIL timeout ch=%0d: got no done after %0d cycles want done", c, n);
      end
   endtask

   task automatic pulse_start(input int c);
      start[c] = 1'b1;
      tick();
      start[c] = 1'b0;
   endtask

   int d0;

   initial begin
      rst    = 1'b1;
      start  = 2'b00;
      pdata0 = '0;
      pdata1 = '0;
      repeat (3) tick();
      check("reset_outputs", {58'h0, busy_w[0], done_w[0], sclk_w[0], sout_w[0], clrn_w[0], pen_w[0]}, 64'h0);
      rst = 1'b0;
      tick();
      check("clrn_release", {63'h0, clrn_w[0]}, 64'h1);
      tick();

      // Single frame with only the end bits set.
      pdata0 = 64'h8000_0000_0000_0001;
      d0 = done_cnt[0];
      pulse_start(0);
      wait_done(0);
      check("a_done_pos", 64'(done_pos[0]), 64'd129);
      repeat (3) tick();
      check("a_rises", 64'(rises[0]), 64'd64);
      check("a_stream", cap[0], 64'h8000_0000_0000_0001 ^ INV);
      check("a_busy_len", 64'(last_busy_len[0]), 64'd129);
      check("a_done_cnt", 64'(done_cnt[0] - d0), 64'd1);
      check("a_pen_idle", {63'h0, pen_w[0]}, 64'h1);

      // Start pulsed and P_Data scrambled during a frame: one frame, original data.
      pdata0 = 64'h0123_4567_89AB_CDEF;
      d0 = done_cnt[0];
      pulse_start(0);
      for (int i = 0; i < 100; i++) begin
         start[0] = i[0];
         pdata0   = ~pdata0 ^ 64'(i);
         tick();
      end
      start[0] = 1'b0;
      wait_done(0);
      repeat (5) tick();
      check("b_done_cnt", 64'(done_cnt[0] - d0), 64'd1);
      check("b_busy_len", 64'(last_busy_len[0]), 64'd129);
      check("b_stream", cap[0], 64'h0123_4567_89AB_CDEF ^ INV);

      // Reset after 20 shift cycles aborts with no done and seg_pen low.
      pdata0 = 64'hFFFF_0000_FFFF_0000;
      d0 = done_cnt[0];
      pulse_start(0);
      repeat (20) tick();
      rst = 1'b1;
      tick();
      check("c_reset_outputs", {58'h0, busy_w[0], done_w[0], sclk_w[0], sout_w[0], clrn_w[0], pen_w[0]}, 64'h0);
      rst = 1'b0;
      repeat (3) tick();
      check("c_no_done", 64'(done_cnt[0] - d0), 64'd0);
      check("c_pen_low", {63'h0, pen_w[0]}, 64'h0);
      check("c_clrn_high", {63'h0, clrn_w[0]}, 64'h1);

      // All-zero pattern: ones on every bit only in the inverting build.
      pdata0 = 64'h0;
      pulse_start(0);
      wait_done(0);
      repeat (2) tick();
      check("d_stream", cap[0], 64'h0 ^ INV);
      check("d_rises", 64'(rises[0]), 64'd64);

      // Start held: back-to-back frames separated by a single idle cycle.
      pdata0   = 64'hA5A5_A5A5_A5A5_A5A5;
      d0       = done_cnt[0];
      start[0] = 1'b1;
      wait_done(0);
      wait_done(0);
      start[0] = 1'b0;
      check("e_stream", cap[0], 64'hA5A5_A5A5_A5A5_A5A5 ^ INV);
      check("e_gap", 64'(last_idle_len[0]), 64'd1);
      repeat (5) tick();
      check("e_done_cnt", 64'(done_cnt[0] - d0), 64'd2);
      check("e_busy_len", 64'(last_busy_len[0]), 64'd129);

      // 16-bit instance.
      pdata1 = 16'h00FF;
      pulse_start(1);
      wait_done(1);
      check("f_done_pos", 64'(done_pos[1]), 64'd33);
      repeat (3) tick();
      check("f_stream", cap[1], (64'h00FF ^ INV) & 64'hFFFF);
      check("f_rises", 64'(rises[1]), 64'd16);
      check("f_busy_len", 64'(last_busy_len[1]), 64'd33);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
